// File: rtl/vec_commit_ctrl.sv
// In-order commit controller between scalar issue/commit logic and rvv_core.
// Define VEC_COMMIT_CTRL_TIMEOUT_EN to build the commit watchdog behind timeout_o.
module vec_commit_ctrl #(
    parameter int unsigned NumEntries    = 8,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned IdWidth       = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [IdWidth-1:0] s_insn_id_i,
    output logic               v_valid_o,
    input  logic               v_ready_i,
    input  logic               resolve_valid_i,
    input  logic [IdWidth-1:0] resolve_id_i,
    input  logic               flush_req_i,
    output logic               insn_can_commit_o,
    output logic [IdWidth-1:0] insn_can_commit_id_o,
    output logic               flush_o,
    input  logic               done_i,
    input  logic [IdWidth-1:0] done_insn_id_i,
    input  logic               illegal_insn_i,
    output logic               retire_o,
    output logic               exception_o,
    output logic               order_err_o,
    output logic               timeout_o
);

    localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam int unsigned PtrW = IdxW + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0]    head_q, head_d;
    logic [PtrW-1:0]    tail_q, tail_d;
    logic [IdWidth-1:0] id_q [NumEntries];
    logic [NumEntries-1:0] res_q;

    logic [IdxW-1:0]    head_idx, tail_idx;
    logic [IdWidth-1:0] head_id;
    logic               empty, full, run, head_res;
    logic               push, pop, resolve_hit, done_bad;

    logic flush_q, retire_q, exception_q, order_err_q;

    // Queue status decoded from the registered pointers
    assign head_idx = head_q[IdxW-1:0];
    assign tail_idx = tail_q[IdxW-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);
    assign head_id  = id_q[head_idx];
    assign head_res = ~empty & res_q[head_idx];
    assign run      = (state_q == RUN);

    // Issue path is a pure pass-through gated by occupancy and state
    assign v_valid_o = s_valid_i & ~full & run;
    assign s_ready_o = v_ready_i & ~full & run;

    assign push        = s_valid_i & s_ready_o;
    assign pop         = done_i & ~empty & (done_insn_id_i == head_id);
    assign done_bad    = done_i & ~pop;
    assign resolve_hit = resolve_valid_i & ~empty & (resolve_id_i == head_id);

    assign insn_can_commit_o    = head_res;
    assign insn_can_commit_id_o = empty ? '0 : head_id;
    assign flush_o              = flush_q;
    assign retire_o             = retire_q;
    assign exception_o          = exception_q;
    assign order_err_o          = order_err_q;

    // Next-state and pointer update
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) tail_d = tail_q + PtrW'(1);
        if (pop)  head_d = head_q + PtrW'(1);
        case (state_q)
            RUN: begin
                if (flush_req_i) state_d = FLUSH;
            end
            FLUSH: begin
                // Only a resolved head survives; a same-cycle pop leaves the queue empty
                tail_d  = (head_res | pop) ? head_q + PtrW'(1) : head_q;
                state_d = (head_res & ~pop) ? DRAIN : RUN;
            end
            DRAIN: begin
                if (pop | empty) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            head_q      <= '0;
            tail_q      <= '0;
            res_q       <= '0;
            flush_q     <= 1'b0;
            retire_q    <= 1'b0;
            exception_q <= 1'b0;
            order_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (resolve_hit) res_q[head_idx] <= 1'b1;
            if (push)        res_q[tail_idx] <= 1'b0;
            flush_q     <= (state_d == FLUSH);
            retire_q    <= pop;
            exception_q <= pop & illegal_insn_i;
            order_err_q <= order_err_q | done_bad;
        end
    end

    // Payload storage needs no reset: entries are only read once pushed
    always_ff @(posedge clk_i) begin
        if (push) id_q[tail_idx] <= s_insn_id_i;
    end

`ifdef VEC_COMMIT_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] wd_cnt_q;
    logic            timeout_q;

    // Watchdog counts committable cycles that see no retire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (insn_can_commit_o & ~pop) begin
            if (wd_cnt_q != CntW'(TimeoutCycles)) wd_cnt_q <= wd_cnt_q + CntW'(1);
            if (wd_cnt_q == CntW'(TimeoutCycles - 1)) timeout_q <= 1'b1;
        end else begin
            wd_cnt_q <= '0;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TimeoutCycles);
    assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_vec_commit_ctrl.sv
// Bench for vec_commit_ctrl: directed test-plan steps then random traffic,
// all checked against a queue-based reference model.
module tb_vec_commit_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 8;
    localparam int unsigned TO = 16;
    localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_valid_i, v_ready_i, resolve_valid_i, flush_req_i, done_i, illegal_insn_i;
    logic [IW-1:0] s_insn_id_i, resolve_id_i, done_insn_id_i;
    logic          s_ready_o, v_valid_o, insn_can_commit_o, flush_o;
    logic          retire_o, exception_o, order_err_o, timeout_o;
    logic [IW-1:0] insn_can_commit_id_o;

    vec_commit_ctrl #(.NumEntries(N), .TimeoutCycles(TO), .IdWidth(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_insn_id_i(s_insn_id_i),
        .v_valid_o(v_valid_o), .v_ready_i(v_ready_i),
        .resolve_valid_i(resolve_valid_i), .resolve_id_i(resolve_id_i),
        .flush_req_i(flush_req_i),
        .insn_can_commit_o(insn_can_commit_o), .insn_can_commit_id_o(insn_can_commit_id_o),
        .flush_o(flush_o), .done_i(done_i), .done_insn_id_i(done_insn_id_i),
        .illegal_insn_i(illegal_insn_i), .retire_o(retire_o), .exception_o(exception_o),
        .order_err_o(order_err_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: in-order list of {id, resolved} plus mode and sticky flags
    logic [IW-1:0] mq_id[$];
    bit            mq_res[$];
    int            mode;
    bit            m_retire, m_exc, m_err, m_to;
    int            tcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_id.delete();
        mq_res.delete();
        mode = M_RUN;
        m_retire = 0; m_exc = 0; m_err = 0; m_to = 0; tcnt = 0;
    endtask

    task automatic drive(input bit sv, input int sid, input bit vr, input bit rv, input int rid,
                         input bit fl, input bit dn, input int did, input bit ill);
        s_valid_i = sv; s_insn_id_i = IW'(sid); v_ready_i = vr;
        resolve_valid_i = rv; resolve_id_i = IW'(rid); flush_req_i = fl;
        done_i = dn; done_insn_id_i = IW'(did); illegal_insn_i = ill;
    endtask

    task automatic model_step();
        int  sz;
        bit  full, push, pop, hres;
        sz   = mq_id.size();
        full = (sz == N);
        push = s_valid_i && v_ready_i && !full && (mode == M_RUN);
        pop  = done_i && (sz > 0) && (done_insn_id_i == mq_id[0]);
        hres = (sz > 0) && mq_res[0];
        if (hres && !pop) begin
            tcnt++;
            if (tcnt >= TO) m_to = 1;
        end else begin
            tcnt = 0;
        end
        if (done_i && !pop) m_err = 1;
        if (resolve_valid_i && (sz > 0) && (resolve_id_i == mq_id[0])) mq_res[0] = 1;
        m_retire = pop;
        m_exc    = pop && illegal_insn_i;
        if (pop) begin
            void'(mq_id.pop_front());
            void'(mq_res.pop_front());
        end
        case (mode)
            M_RUN: if (flush_req_i) mode = M_FLUSH;
            M_FLUSH: begin
                // Everything past an already-resolved head is speculative and dropped
                while (mq_id.size() > ((hres && !pop) ? 1 : 0)) begin
                    void'(mq_id.pop_back());
                    void'(mq_res.pop_back());
                end
                mode = (mq_id.size() > 0) ? M_DRAIN : M_RUN;
            end
            default: if (pop || sz == 0) mode = M_RUN;
        endcase
        if (push) begin
            mq_id.push_back(s_insn_id_i);
            mq_res.push_back(1'b0);
        end
    endtask

    // One clock: check issue handshake, take the edge, then check registered outputs
    task automatic cycle();
        bit full, run;
        #2;
        full = (mq_id.size() == N);
        run  = (mode == M_RUN);
        check("s_ready", 32'(s_ready_o), 32'(v_ready_i && !full && run));
        check("v_valid", 32'(v_valid_o), 32'(s_valid_i && !full && run));
        @(posedge clk_i);
        model_step();
        #1;
        check("can_commit", 32'(insn_can_commit_o), 32'((mq_id.size() > 0) && mq_res[0]));
        check("commit_id", 32'(insn_can_commit_id_o), (mq_id.size() > 0) ? 32'(mq_id[0]) : 32'd0);
        check("flush", 32'(flush_o), 32'(mode == M_FLUSH));
        check("retire", 32'(retire_o), 32'(m_retire));
        check("exception", 32'(exception_o), 32'(m_exc));
        check("order_err", 32'(order_err_o), 32'(m_err));
`ifdef VEC_COMMIT_CTRL_TIMEOUT_EN
        check("timeout", 32'(timeout_o), 32'(m_to));
`else
        check("timeout", 32'(timeout_o), 32'd0);
`endif
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    // Asynchronous reset, released away from the clock edge
    task automatic do_reset();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        model_reset();
        #2;
        check("rst_can_commit", 32'(insn_can_commit_o), 32'd0);
        check("rst_commit_id", 32'(insn_can_commit_id_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_retire", 32'(retire_o), 32'd0);
        check("rst_exception", 32'(exception_o), 32'd0);
        check("rst_order_err", 32'(order_err_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_s_ready", 32'(s_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int hid;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // In-order issue, resolve, retire of 0,1,2
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, i, 0, 0, 0, 0);
            cycle();
            check("t1_commit_id", 32'(insn_can_commit_id_o), 32'(i));
            drive(0, 0, 1, 0, 0, 0, 1, i, 0);
            cycle();
            check("t1_retire", 32'(retire_o), 32'd1);
        end
        check("t1_empty", 32'(insn_can_commit_id_o), 32'd0);

        // Fill to capacity; 9th offer is refused until the head retires
        for (int i = 0; i < 8; i++) begin
            drive(1, 10 + i, 1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 18, 1, 1, 10, 0, 0, 0, 0);
        #2;
        check("t2_full_ready", 32'(s_ready_o), 32'd0);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 1, 10, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        #2;
        check("t2_ready_back", 32'(s_ready_o), 32'd1);
        drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
        cycle();
        idle_cycles(2);

        // Flush keeps only the resolved head, drains it, then returns to RUN
        for (int i = 0; i < 3; i++) begin
            drive(1, i, 1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
        cycle();
        check("t3_flush_pulse", 32'(flush_o), 32'd1);
        idle_cycles(1);
        check("t3_flush_once", 32'(flush_o), 32'd0);
        check("t3_head_kept", 32'(insn_can_commit_id_o), 32'd0);
        drive(1, 9, 1, 0, 0, 1, 0, 0, 0);
        #2;
        check("t3_drain_blocks", 32'(s_ready_o), 32'd0);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 1, 0, 0);
        cycle();
        #2;
        check("t3_run_again", 32'(s_ready_o), 32'd1);

        // Mismatched resolve is ignored; mismatched done flags an ordering error
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 1, 5, 0, 0, 0, 0);
        cycle();
        check("t4_no_commit", 32'(insn_can_commit_o), 32'd0);
        drive(0, 0, 1, 0, 0, 0, 1, 4, 0);
        cycle();
        check("t4_order_err", 32'(order_err_o), 32'd1);
        check("t4_no_pop", 32'(insn_can_commit_id_o), 32'd3);
        drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
        cycle();
        idle_cycles(1);

        // Illegal instruction retires with an exception
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 1, 2, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 1, 2, 1);
        cycle();
        check("t5_retire", 32'(retire_o), 32'd1);
        check("t5_exception", 32'(exception_o), 32'd1);

        // Resolved head held without retire (watchdog window)
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 1, 7, 0, 0, 0, 0);
        cycle();
        idle_cycles(TO + 2);
        drive(0, 0, 1, 0, 0, 0, 1, 7, 0);
        cycle();

        // Mid-operation reset drops in-flight entries
        drive(1, 40, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 41, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        do_reset();
        idle_cycles(1);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            hid = (mq_id.size() > 0) ? int'(mq_id[0]) : int'($urandom_range(0, 255));
            drive(($urandom_range(0, 9) < 6), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 8) ? hid : int'($urandom_range(0, 255)),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 19) < 19) ? hid : int'($urandom_range(0, 255)),
                  ($urandom_range(0, 4) == 0));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
